// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT window at BASE_ADDR,
// one-shot or auto-reload countdown with a maskable interrupt request.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0]  MODE_AUTO   = 2'b01;
  localparam logic [1:0]  SEL_CTRL    = 2'd0;
  localparam logic [1:0]  SEL_PRESET  = 2'd1;
  localparam logic [1:0]  SEL_COUNT   = 2'd2;
  localparam logic [31:0] WINDOW_SIZE = 32'd12;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic [31:0] offset_s;
  logic        hit_s;
  logic [1:0]  reg_sel_s;
  logic        wr_ctrl_s;
  logic        wr_preset_s;
  logic        fsm_en_s;
  logic        fsm_flag_s;

  // Addresses below the base wrap to huge offsets, so one compare covers both ends.
  assign offset_s    = addr - BASE_ADDR;
  assign hit_s       = (offset_s < WINDOW_SIZE);
  assign reg_sel_s   = offset_s[3:2];
  assign wr_ctrl_s   = we & hit_s & (reg_sel_s == SEL_CTRL);
  assign wr_preset_s = we & hit_s & (reg_sel_s == SEL_PRESET);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fsm_en_s   = ctrl_q[0];
    fsm_flag_s = irq_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // A count of 0 (PRESET=0) expires exactly like a count of 1.
          count_d    = 32'd0;
          fsm_flag_s = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == MODE_AUTO) begin
          fsm_flag_s = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          fsm_en_s = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A CPU CTRL write overrides the FSM's EN clear and always clears the flag.
  assign ctrl_d     = wr_ctrl_s ? wd[3:0] : {ctrl_q[3:1], fsm_en_s};
  assign irq_flag_d = wr_ctrl_s ? 1'b0 : fsm_flag_s;
  assign preset_d   = wr_preset_s ? wd : preset_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    if (hit_s) begin
      case (reg_sel_s)
        SEL_CTRL:   rd = {28'd0, ctrl_q};
        SEL_PRESET: rd = preset_q;
        SEL_COUNT:  rd = count_q;
        default:    rd = 32'd0;
      endcase
    end else begin
      rd = 32'd0;
    end
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios plus random traffic,
// checked against a behavioural model of the register/countdown rules.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7f00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = BASE;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;

  always #5 clk = ~clk;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc_no = 0;

  // Reference model: timer phase held as independent flags; none set means idle.
  bit          m_en, m_im, m_flag;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count;
  bit          m_loading, m_counting, m_intr;

  bit          cur_r = 1'b1, cur_w = 1'b0;
  logic [31:0] cur_a = BASE, cur_d = 32'd0;

  function automatic int reg_index(logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off < 32'd12) return int'(off) / 4;
    return -1;
  endfunction

  function automatic logic [31:0] model_rd(logic [31:0] a);
    case (reg_index(a))
      0: return {28'd0, m_im, m_mode, m_en};
      1: return m_preset;
      2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_edge(bit r, bit w, logic [31:0] a, logic [31:0] d);
    bit          n_en, n_flag, n_loading, n_counting, n_intr;
    logic [31:0] n_count;
    if (r) begin
      m_en = 0; m_im = 0; m_flag = 0; m_mode = 2'd0;
      m_preset = 32'd0; m_count = 32'd0;
      m_loading = 0; m_counting = 0; m_intr = 0;
      return;
    end
    n_en = m_en; n_flag = m_flag; n_count = m_count;
    n_loading = 0; n_counting = 0; n_intr = 0;
    if (m_loading) begin
      n_count = m_preset;
      n_counting = 1;
    end else if (m_counting) begin
      if (!m_en) begin
        // back to idle, count frozen
      end else if (m_count > 1) begin
        n_count = m_count - 1;
        n_counting = 1;
      end else begin
        n_count = 0;
        n_flag = 1;
        n_intr = 1;
      end
    end else if (m_intr) begin
      if (m_mode == 2'd1) begin
        n_flag = 0;
        n_loading = 1;
      end else begin
        n_en = 0;
      end
    end else if (m_en) begin
      n_loading = 1;
    end
    if (w && reg_index(a) == 0) begin
      n_en = d[0]; m_mode = d[2:1]; m_im = d[3]; n_flag = 0;
    end
    if (w && reg_index(a) == 1) m_preset = d;
    m_en = n_en; m_flag = n_flag; m_count = n_count;
    m_loading = n_loading; m_counting = n_counting; m_intr = n_intr;
  endfunction

  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    model_edge(cur_r, cur_w, cur_a, cur_d);
    reset = r; we = w; addr = a; wd = d;
    cur_r = r; cur_w = w; cur_a = a; cur_d = d;
    cyc_no++;
    e.rd = model_rd(a);
    e.irq = m_flag & m_im;
    e.cyc = cyc_no;
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, 32'd0);
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if (rd === e.rd) n_pass++;
        else $display("FAIL rd cyc=%0d addr=%h got=%h expected=%h", e.cyc, addr, rd, e.rd);
        n_checks++;
        if (irq === e.irq) n_pass++;
        else $display("FAIL irq cyc=%0d got=%b expected=%b", e.cyc, irq, e.irq);
      end
    end
  end

  initial begin
    logic [31:0] addr_pool [0:9];
    logic [31:0] a, d;
    int          k;
    addr_pool = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE - 32'h4,
                  BASE + 32'h10, BASE + 32'h1, BASE + 32'hA, 32'h0000_7f10, 32'h0};

    // Reset and empty register reads
    cyc(1'b1, 1'b0, BASE, 32'd0);
    cyc(1'b1, 1'b0, BASE, 32'd0);
    idle(1, BASE); idle(1, BASE + 32'h4); idle(1, BASE + 32'h8);

    // One-shot with IM, sticky irq, cleared by CTRL write
    wr(BASE + 32'h4, 32'd3);
    wr(BASE, 32'h9);
    idle(8, BASE + 32'h8);
    idle(2, BASE);
    wr(BASE, 32'h8);
    idle(3, BASE);

    // Auto-reload pulses
    wr(BASE + 32'h4, 32'd2);
    wr(BASE, 32'hB);
    idle(14, BASE + 32'h8);
    wr(BASE, 32'h0);
    idle(3, BASE + 32'h8);

    // Stop mid-count
    wr(BASE + 32'h4, 32'd10);
    wr(BASE, 32'h1);
    for (int i = 0; i < 30 && m_count != 32'd6; i++) idle(1, BASE + 32'h8);
    wr(BASE, 32'h0);
    idle(5, BASE + 32'h8);

    // PRESET=0 and a PRESET write during counting
    wr(BASE + 32'h4, 32'd0);
    wr(BASE, 32'h9);
    idle(6, BASE + 32'h8);
    wr(BASE + 32'h4, 32'd4);
    wr(BASE, 32'hB);
    idle(3, BASE + 32'h8);
    wr(BASE + 32'h4, 32'd1);
    idle(10, BASE + 32'h8);
    wr(BASE, 32'h0);
    idle(2, BASE);

    // IM=0 run: flag sets internally, irq never rises
    wr(BASE + 32'h4, 32'd1);
    wr(BASE, 32'h1);
    idle(6, BASE + 32'h8);
    wr(BASE, 32'h8);
    idle(3, BASE);

    // Reset mid-count, then dropped writes
    wr(BASE + 32'h4, 32'd6);
    wr(BASE, 32'hB);
    for (int i = 0; i < 30 && !(m_counting && m_count == 32'd4); i++) idle(1, BASE + 32'h8);
    cyc(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    idle(2, BASE);
    wr(BASE + 32'h8, 32'd5);
    idle(1, BASE + 32'h8);
    wr(BASE + 32'hC, 32'd7);
    idle(1, BASE + 32'hC);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(0, 9);
      a = addr_pool[k];
      d = $urandom;
      if (reg_index(a) == 1) d = $urandom_range(0, 6);
      if (reg_index(a) == 0 && $urandom_range(0, 1) == 1) d = d | 32'h1;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, a, d);
    end
    idle(2, BASE);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d expected=0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
